// File: rtl/branch_pkg.sv
// Shared defaults and sizing helpers for the branch prediction checker.
package branch_pkg;

  localparam int unsigned DefaultDepth = 4;
  localparam int unsigned DefaultCntW  = 16;

  // One extra bit so a completely full queue is representable.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order 1-bit queue of outstanding branch predictions with a whole-queue flush.
module pred_fifo
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic                         head_data,
  output logic [occ_width(DEPTH)-1:0]  occupancy,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned OW = occ_width(DEPTH);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [OW-1:0] cnt_q;
  logic          mem_q [DEPTH];
  logic          push_en, pop_en;

  assign full      = (cnt_q == OW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign occupancy = cnt_q;
  assign head_data = mem_q[rd_ptr_q];

  // A flush wins over a same-cycle push: that entry is wrong-path.
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + OW'(push_en) - OW'(pop_en);
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/branch_checker.sv
// Compares queued predictions against resolved outcomes; drives predictor updates,
// flush requests and hit/miss statistics.
module branch_checker
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pred_valid,
  input  logic                         pred_taken,
  output logic                         pred_ready,
  input  logic                         res_valid,
  input  logic                         res_taken,
  output logic                         upd_result,
  output logic                         upd_taken,
  output logic                         mispredict,
  output logic [occ_width(DEPTH)-1:0]  occupancy,
  output logic [CNT_W-1:0]             hit_count,
  output logic [CNT_W-1:0]             miss_count,
  output logic                         overflow_err,
  output logic                         underflow_err
);

  logic full, empty, head;
  logic push, pop, miss_now;

  assign pred_ready = !full;
  assign push       = pred_valid && !full;
  assign pop        = res_valid && !empty;
  assign miss_now   = pop && (head != res_taken);

  pred_fifo #(
    .DEPTH (DEPTH)
  ) u_pred_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (pred_taken),
    .pop       (pop),
    .flush     (miss_now),
    .head_data (head),
    .occupancy (occupancy),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_result    <= 1'b0;
      upd_taken     <= 1'b0;
      mispredict    <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      upd_result <= pop;
      upd_taken  <= pop && res_taken;
      mispredict <= miss_now;
      if (pop && !miss_now && (hit_count != '1)) hit_count <= hit_count + CNT_W'(1);
      if (miss_now && (miss_count != '1))        miss_count <= miss_count + CNT_W'(1);
      if (pred_valid && full) overflow_err  <= 1'b1;
      if (res_valid && empty) underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_checker.sv
// Directed plus randomized bench for branch_checker, checked against a queue-based model.
module tb_branch_checker;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pred_valid, pred_taken, res_valid, res_taken;

  logic       pred_ready, upd_result, upd_taken, mispredict, overflow_err, underflow_err;
  logic [2:0] occupancy;
  logic [15:0] hit_count, miss_count;

  logic       pred_ready2, upd_result2, upd_taken2, mispredict2, overflow_err2, underflow_err2;
  logic [2:0] occupancy2;
  logic [1:0] hit_count2, miss_count2;

  int checks = 0;
  int failures = 0;

  bit mq[$];
  int m_hits, m_miss;
  bit m_ovf, m_unf, m_upd, m_ut, m_mis;

  always #5 clk = ~clk;

  branch_checker #(.DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk (clk), .rst_n (rst_n),
    .pred_valid (pred_valid), .pred_taken (pred_taken), .pred_ready (pred_ready),
    .res_valid (res_valid), .res_taken (res_taken),
    .upd_result (upd_result), .upd_taken (upd_taken), .mispredict (mispredict),
    .occupancy (occupancy), .hit_count (hit_count), .miss_count (miss_count),
    .overflow_err (overflow_err), .underflow_err (underflow_err)
  );

  branch_checker #(.DEPTH(DEPTH), .CNT_W(2)) dut_sat (
    .clk (clk), .rst_n (rst_n),
    .pred_valid (pred_valid), .pred_taken (pred_taken), .pred_ready (pred_ready2),
    .res_valid (res_valid), .res_taken (res_taken),
    .upd_result (upd_result2), .upd_taken (upd_taken2), .mispredict (mispredict2),
    .occupancy (occupancy2), .hit_count (hit_count2), .miss_count (miss_count2),
    .overflow_err (overflow_err2), .underflow_err (underflow_err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (2 ** w - 1)) ? (2 ** w - 1) : v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_hits = 0; m_miss = 0;
    m_ovf = 0; m_unf = 0; m_upd = 0; m_ut = 0; m_mis = 0;
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".upd_result"}, 32'(upd_result), 32'(m_upd));
    check({ctx, ".upd_taken"}, 32'(upd_taken), 32'(m_ut));
    check({ctx, ".mispredict"}, 32'(mispredict), 32'(m_mis));
    check({ctx, ".occupancy"}, 32'(occupancy), mq.size());
    check({ctx, ".hit_count"}, 32'(hit_count), sat(m_hits, 16));
    check({ctx, ".miss_count"}, 32'(miss_count), sat(m_miss, 16));
    check({ctx, ".overflow_err"}, 32'(overflow_err), 32'(m_ovf));
    check({ctx, ".underflow_err"}, 32'(underflow_err), 32'(m_unf));
    check({ctx, ".sat_hit"}, 32'(hit_count2), sat(m_hits, 2));
    check({ctx, ".sat_miss"}, 32'(miss_count2), sat(m_miss, 2));
    check({ctx, ".sat_occ"}, 32'(occupancy2), mq.size());
  endtask

  // One clock of stimulus; called just after a falling edge, returns at the next one.
  task automatic cycle(input string ctx, input bit pv, input bit pt, input bit rv, input bit rt);
    bit full_now, empty_now, push, head;
    pred_valid = pv; pred_taken = pt; res_valid = rv; res_taken = rt;
    #1;
    check({ctx, ".pred_ready"}, 32'(pred_ready), 32'(mq.size() != DEPTH));
    @(posedge clk);
    full_now  = (mq.size() == DEPTH);
    empty_now = (mq.size() == 0);
    push = pv && !full_now;
    if (pv && full_now) m_ovf = 1;
    if (rv && empty_now) m_unf = 1;
    m_upd = 0; m_ut = 0; m_mis = 0;
    if (rv && !empty_now) begin
      head  = mq.pop_front();
      m_upd = 1;
      m_ut  = rt;
      if (head == rt) m_hits++;
      else begin
        m_miss++;
        m_mis = 1;
        mq.delete();
        push = 0;
      end
    end
    if (push) mq.push_back(pt);
    #1;
    check_all(ctx);
    @(negedge clk);
  endtask

  initial begin
    pred_valid = 0; pred_taken = 0; res_valid = 0; res_taken = 0;
    rst_n = 0;
    model_reset();
    #2;
    check("reset.pred_ready", 32'(pred_ready), 1);
    check_all("reset");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Three hits in order.
    cycle("hit_push0", 1, 1, 0, 0);
    cycle("hit_push1", 1, 0, 0, 0);
    cycle("hit_push2", 1, 1, 0, 0);
    cycle("hit_res0", 0, 0, 1, 1);
    cycle("hit_res1", 0, 0, 1, 0);
    cycle("hit_res2", 0, 0, 1, 1);
    check("hits.hit_count", 32'(hit_count), 3);
    check("hits.miss_count", 32'(miss_count), 0);

    // Mispredict flushes the rest of the queue.
    cycle("miss_push0", 1, 1, 0, 0);
    cycle("miss_push1", 1, 1, 0, 0);
    cycle("miss_push2", 1, 0, 0, 0);
    check("miss.occ_before", 32'(occupancy), 3);
    cycle("miss_res", 1, 1, 1, 0);
    check("miss.mispredict", 32'(mispredict), 1);
    check("miss.occ_after", 32'(occupancy), 0);
    check("miss.miss_count", 32'(miss_count), 1);
    cycle("miss_idle", 0, 0, 0, 0);
    check("miss.pulse_once", 32'(mispredict), 0);

    // Full queue drops a push even with a same-cycle pop.
    for (int i = 0; i < int'(DEPTH); i++) cycle("fill", 1, 1, 0, 0);
    check("full.pred_ready", 32'(pred_ready), 0);
    cycle("full_pushpop", 1, 0, 1, 1);
    check("full.overflow", 32'(overflow_err), 1);
    check("full.occupancy", 32'(occupancy), 3);
    for (int i = 0; i < 3; i++) cycle("drain", 0, 0, 1, 1);

    // Resolve while empty.
    cycle("empty_res", 0, 0, 1, 1);
    check("empty.upd_result", 32'(upd_result), 0);
    check("empty.underflow", 32'(underflow_err), 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 9) < 5),
            1'($urandom));
    end

    // Asynchronous reset between edges with an update pulse pending.
    while (mq.size() != 0) cycle("pre_rst_drain", 0, 0, 1, mq[0]);
    cycle("rst_push0", 1, 1, 0, 0);
    cycle("rst_push1", 1, 0, 0, 0);
    cycle("rst_push2", 1, 1, 0, 0);
    cycle("rst_res", 0, 0, 1, 1);
    check("rst.occ_before", 32'(occupancy), 2);
    check("rst.upd_before", 32'(upd_result), 1);
    pred_valid = 0; res_valid = 0;
    rst_n = 0;
    model_reset();
    #1;
    check("rst.upd_result", 32'(upd_result), 0);
    check("rst.upd_taken", 32'(upd_taken), 0);
    check("rst.occupancy", 32'(occupancy), 0);
    check("rst.pred_ready", 32'(pred_ready), 1);
    check_all("rst");
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Five hits saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      cycle("sat_push", 1, 1, 0, 0);
      cycle("sat_res", 0, 0, 1, 1);
    end
    check("sat.hit_count2", 32'(hit_count2), 3);
    check("sat.hit_count", 32'(hit_count), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_checker.md
BRANCH_CHECKER -- requirements
Module: branch_checker

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of in-flight prediction entries; legal values are powers of two, 2..16.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the hit and miss statistics counters.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; it SHALL be asynchronous and active-low.
REQ-005 pred_valid  input  1  a predictor output is present this cycle (asserted the cycle after the predictor's request).
REQ-006 pred_taken  input  1  predicted direction (1 = taken).
REQ-007 pred_ready  output  1  combinational; SHALL equal !full.
REQ-008 res_valid  input  1  the oldest outstanding branch has resolved this cycle.
REQ-009 res_taken  input  1  actual direction of the resolved branch.
REQ-010 upd_result  output  1  registered one-cycle pulse that drives the predictor's result input.
REQ-011 upd_taken  output  1  registered; actual direction accompanying upd_result.
REQ-012 mispredict  output  1  registered one-cycle pulse requesting a pipeline flush.
REQ-013 occupancy  output  $clog2(DEPTH)+1  number of valid entries.
REQ-014 hit_count, miss_count  output  CNT_W  saturating statistics counters.
REQ-015 overflow_err, underflow_err  output  1  sticky error flags.

Function
REQ-016 The block SHALL hold predictions in an in-order queue; a push SHALL occur when pred_valid && !full.
REQ-017 A pop SHALL occur when res_valid && !empty; the popped entry SHALL be the oldest one.
REQ-018 On a pop, the block SHALL assert upd_result=1 and upd_taken=res_taken on the next cycle, each for exactly one cycle.
REQ-019 On a pop where the head entry differs from res_taken, mispredict SHALL pulse on the next cycle and miss_count SHALL increment.
REQ-020 On a pop where the head entry matches res_taken, hit_count SHALL increment and mispredict SHALL stay 0.
REQ-021 On a mispredicting pop, all remaining entries SHALL be discarded at that edge and occupancy SHALL become 0.
REQ-022 A push in the same cycle as a mispredicting pop SHALL be discarded, because it is wrong-path.
REQ-023 A simultaneous push and non-mispredicting pop SHALL leave occupancy unchanged and enqueue the new entry behind the remaining ones.
REQ-024 When full, pred_valid SHALL be dropped even if a pop occurs in the same cycle, and overflow_err SHALL set.
REQ-025 When empty, res_valid SHALL be ignored, no update pulse SHALL be generated, and underflow_err SHALL set.
REQ-026 hit_count and miss_count SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-027 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; full and empty SHALL be derived from occupancy.
REQ-028 Error flags SHALL clear only on reset.

Reset
REQ-029 On rst_n low, the block SHALL immediately clear occupancy and both pointers, and drive 0 on upd_result, upd_taken, mispredict, hit_count, miss_count, overflow_err and underflow_err; pred_ready SHALL be 1.
REQ-030 Reset asserted mid-operation SHALL discard all entries and suppress any pending update pulse.
REQ-031 Queue storage contents SHALL NOT need reset.

Structure
REQ-032 Package branch_pkg SHALL hold the DEPTH and CNT_W defaults and a function computing the occupancy width.
REQ-033 The queue SHALL be a sub-module pred_fifo, 1 bit wide, with push, pop, flush, occupancy, full and empty.
REQ-034 Comparison, pulse generation and statistics logic SHALL reside in branch_checker.

Verification
REQ-035 Push 1,0,1 and then resolve 1,0,1 -> three upd_result pulses with upd_taken 1,0,1; hit_count=3; mispredict never asserted.
REQ-036 Push 1,1,0 and resolve 0 -> mispredict pulses once; miss_count=1; occupancy goes from 3 to 0 the cycle after the resolve.
REQ-037 Fill to DEPTH=4, then push and pop in the same cycle -> push dropped; overflow_err=1; occupancy=3.
REQ-038 res_valid while empty -> no upd_result; underflow_err=1; counters unchanged.
REQ-039 With CNT_W=2, perform 5 hits -> hit_count saturates at 3.
REQ-040 Drop rst_n asynchronously between clock edges with 2 entries queued -> all outputs 0 immediately; occupancy=0; pred_ready=1.
